epp_port: RTL and testbench

Slave-side handler for the host parallel-port EPP bus; it sits directly upstream of `wacCtrl`. It synchronises the asynchronous EPP strobes and runs the address-write, data-write and data-read cycles. It produces the wait handshake towards the host. Each data write becomes the single-cycle active-low `dataStb` pulse plus a data byte consumed by `wacCtrl`, and each read returns a byte supplied by the back end.

---
 rtl/epp_pkg.sv | 20 ++
 rtl/epp_port_sync_bit.sv | 26 ++
 rtl/epp_port.sv | 132 +++++++++++++
 tb/tb_epp_port.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epp_pkg.sv
// Shared definitions for the EPP slave port: FSM encoding, bus direction
// meaning and the idle level of the write strobe towards wacCtrl.
`timescale 1ns/1ps
package epp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_WR,
    A_RD,
    D_WR,
    D_RD,
    HOLD,
    STALL
  } eppState;

  localparam logic EPP_WR        = 1'b0;
  localparam logic EPP_RD        = 1'b1;
  localparam logic DATA_STB_IDLE = 1'b1;

endpackage

// File: rtl/epp_port_sync_bit.sv
// Single-bit flip-flop synchroniser for asynchronous EPP inputs, with a
// configurable reset level so strobes come out of reset inactive.
`timescale 1ns/1ps
module sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/epp_port.sv
// EPP slave handler: synchronises host strobes, runs address/data write and
// read cycles, drives the wait handshake and feeds write bytes to wacCtrl.
`timescale 1ns/1ps
module epp_port
  import epp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       astb,
  input  logic       dstb,
  input  logic       pwr,
  input  logic [7:0] dbIn,
  output logic [7:0] dbOut,
  output logic       dbOe,
  output logic       pwait,
  output logic [7:0] regAddr,
  output logic [7:0] dataOut,
  output logic       dataStb,
  input  logic [7:0] dataIn,
  output logic       rdStb,
  input  logic       errClr,
  output logic       timeoutErr
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic    astbSync;
  logic    dstbSync;
  logic    pwrSync;
  eppState state;
  logic [7:0] holdCnt;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) astbSyncInst (
    .clk(clk), .rst(rst), .d(astb), .q(astbSync)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) dstbSyncInst (
    .clk(clk), .rst(rst), .d(dstb), .q(dstbSync)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) pwrSyncInst (
    .clk(clk), .rst(rst), .d(pwr), .q(pwrSync)
  );

  // In D_RD the registered rdStb doubles as the "request already issued" flag,
  // giving the back end one full cycle before dataIn is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      holdCnt    <= 8'h00;
      dbOut      <= 8'h00;
      dbOe       <= 1'b0;
      pwait      <= 1'b0;
      regAddr    <= 8'h00;
      dataOut    <= 8'h00;
      dataStb    <= DATA_STB_IDLE;
      rdStb      <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      dataStb <= DATA_STB_IDLE;
      rdStb   <= 1'b0;
      if (errClr) begin
        timeoutErr <= 1'b0;
      end
      case (state)
        IDLE: begin
          holdCnt <= 8'h00;
          if (!astbSync) begin
            state <= (pwrSync == EPP_RD) ? A_RD : A_WR;
          end else if (!dstbSync) begin
            state <= (pwrSync == EPP_RD) ? D_RD : D_WR;
          end
        end
        A_WR: begin
          regAddr <= dbIn;
          pwait   <= 1'b1;
          state   <= HOLD;
        end
        A_RD: begin
          dbOut <= regAddr;
          dbOe  <= 1'b1;
          pwait <= 1'b1;
          state <= HOLD;
        end
        D_WR: begin
          dataOut <= dbIn;
          dataStb <= ~DATA_STB_IDLE;
          pwait   <= 1'b1;
          state   <= HOLD;
        end
        D_RD: begin
          if (!rdStb) begin
            rdStb <= 1'b1;
          end else begin
            dbOut <= dataIn;
            dbOe  <= 1'b1;
            pwait <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (astbSync && dstbSync) begin
            pwait   <= 1'b0;
            dbOe    <= 1'b0;
            holdCnt <= 8'h00;
            state   <= IDLE;
          end else if (holdCnt == TIMEOUT_LAST) begin
            pwait      <= 1'b0;
            dbOe       <= 1'b0;
            timeoutErr <= 1'b1;
            holdCnt    <= 8'h00;
            state      <= STALL;
          end else begin
            holdCnt <= holdCnt + 8'd1;
          end
        end
        STALL: begin
          if (astbSync && dstbSync) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epp_port.sv
// Scoreboard bench for epp_port: host cycles push expected responses, a
// negedge monitor checks them when pwait rises/falls and tracks strobe pulses.
`timescale 1ns/1ps
module tb_epp_port;

  localparam int TB_TIMEOUT = 255;

  typedef enum int {REL_NORMAL, REL_TIMEOUT, REL_RESET} relKind;

  typedef struct {
    string      tag;
    logic [7:0] regAddr;
    logic [7:0] dataOut;
    logic [7:0] dbOut;
    logic       dbOe;
    logic       dataStb;
    logic       timeoutErr;
    int         riseLat;
    relKind     rel;
  } expRec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       astb = 1'b1;
  logic       dstb = 1'b1;
  logic       pwr = 1'b0;
  logic [7:0] dbIn = 8'h00;
  logic [7:0] dataIn = 8'h00;
  logic       errClr = 1'b0;
  logic [7:0] dbOut;
  logic       dbOe;
  logic       pwait;
  logic [7:0] regAddr;
  logic [7:0] dataOut;
  logic       dataStb;
  logic       rdStb;
  logic       timeoutErr;

  int checks = 0;
  int failures = 0;

  expRec expQ[$];
  logic [7:0] modelAddr = 8'h00;
  logic [7:0] modelData = 8'h00;
  logic       modelErr = 1'b0;
  int expDataPulses = 0;
  int expRdPulses = 0;

  int dataPulses = 0;
  int rdPulses = 0;
  int dataStbWidth = 0;
  int rdStbWidth = 0;
  int lowCnt = 0;
  int relCnt = 0;
  int highCnt = 0;
  logic prevPwait = 1'b0;
  expRec cur;

  epp_port #(.SYNC_STAGES(2), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .astb(astb), .dstb(dstb), .pwr(pwr), .dbIn(dbIn),
    .dbOut(dbOut), .dbOe(dbOe), .pwait(pwait), .regAddr(regAddr),
    .dataOut(dataOut), .dataStb(dataStb), .dataIn(dataIn), .rdStb(rdStb),
    .errClr(errClr), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Model the host cycle and queue what the port must present when pwait rises.
  task automatic expectCycle(input string tag, input bit useA, input bit useD, input bit rd,
                             input logic [7:0] bus, input logic [7:0] rdData, input relKind rel);
    expRec rec;
    rec.tag = tag;
    rec.rel = rel;
    rec.dbOe = 1'b0;
    rec.dbOut = 8'h00;
    rec.dataStb = 1'b1;
    rec.riseLat = 4;
    if (useA) begin
      if (rd) begin
        rec.dbOe = 1'b1;
        rec.dbOut = modelAddr;
      end else begin
        modelAddr = bus;
      end
    end else if (useD) begin
      if (rd) begin
        rec.dbOe = 1'b1;
        rec.dbOut = rdData;
        rec.riseLat = 5;
        expRdPulses++;
      end else begin
        modelData = bus;
        rec.dataStb = 1'b0;
        expDataPulses++;
      end
    end
    rec.regAddr = modelAddr;
    rec.dataOut = modelData;
    rec.timeoutErr = modelErr;
    if (rel == REL_TIMEOUT) modelErr = 1'b1;
    expQ.push_back(rec);
  endtask

  task automatic waitPwait(input string tag, input logic level, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pwait === level) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.waitPwait: got 0x%0h, want 0x%0h", tag, pwait, level);
    end
  endtask

  task automatic hostFinish(input string tag, input relKind rel);
    waitPwait(tag, 1'b1, 20);
    if (rel == REL_NORMAL) begin
      @(posedge clk); #1;
      astb = 1'b1;
      dstb = 1'b1;
      waitPwait(tag, 1'b0, 20);
      repeat (3) @(posedge clk);
    end else if (rel == REL_TIMEOUT) begin
      waitPwait(tag, 1'b0, 400);
      repeat (40) @(posedge clk);
    end
  endtask

  task automatic applyStimulus(input string tag, input bit useA, input bit useD, input bit rd,
                               input logic [7:0] bus, input logic [7:0] rdData, input relKind rel);
    expectCycle(tag, useA, useD, rd, bus, rdData, rel);
    @(posedge clk); #1;
    pwr = rd;
    dbIn = bus;
    dataIn = rdData;
    astb = !useA;
    dstb = !useD;
    hostFinish(tag, rel);
  endtask

  // Monitor: compare queued expectations on pwait edges, measure latencies and pulse widths.
  always @(negedge clk) begin
    if (!rst && !prevPwait && pwait) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRise", 1, 0);
      end else begin
        cur = expQ[0];
        checkOutput({cur.tag, ".regAddr"}, regAddr, cur.regAddr);
        checkOutput({cur.tag, ".dataOut"}, dataOut, cur.dataOut);
        checkOutput({cur.tag, ".dataStb"}, dataStb, cur.dataStb);
        checkOutput({cur.tag, ".dbOe"}, dbOe, cur.dbOe);
        if (cur.dbOe) checkOutput({cur.tag, ".dbOut"}, dbOut, cur.dbOut);
        checkOutput({cur.tag, ".timeoutErr"}, timeoutErr, cur.timeoutErr);
        checkOutput({cur.tag, ".riseLatency"}, lowCnt, cur.riseLat);
      end
    end
    if (prevPwait && !pwait) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFall", 1, 0);
      end else begin
        cur = expQ.pop_front();
        checkOutput({cur.tag, ".dbOeAtFall"}, dbOe, 0);
        case (cur.rel)
          REL_NORMAL:  checkOutput({cur.tag, ".releaseLatency"}, relCnt, 3);
          REL_TIMEOUT: begin
            checkOutput({cur.tag, ".holdCycles"}, highCnt, TB_TIMEOUT);
            checkOutput({cur.tag, ".timeoutErrSet"}, timeoutErr, 1);
          end
          default:     checkOutput({cur.tag, ".fallUnderReset"}, rst, 1);
        endcase
      end
    end
    if (rst) begin
      lowCnt = 0;
      relCnt = 0;
      highCnt = 0;
    end else begin
      if (astb && dstb) lowCnt = 0;
      else if (!pwait) lowCnt++;
      if (!(astb && dstb)) relCnt = 0;
      else if (pwait) relCnt++;
      if (pwait) highCnt++;
      else highCnt = 0;
    end
    if (dataStb === 1'b0) begin
      dataStbWidth++;
    end else if (dataStbWidth != 0) begin
      checkOutput("dataStbWidth", dataStbWidth, 1);
      dataPulses++;
      dataStbWidth = 0;
    end
    if (rdStb === 1'b1) begin
      rdStbWidth++;
    end else if (rdStbWidth != 0) begin
      checkOutput("rdStbWidth", rdStbWidth, 1);
      rdPulses++;
      rdStbWidth = 0;
    end
    prevPwait = pwait;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got 0x0, want 0x1");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    astb = 1'($urandom);
    dstb = 1'($urandom);
    pwr = 1'($urandom);
    dbIn = 8'($urandom);
    dataIn = 8'($urandom);
    errClr = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.dbOut", dbOut, 8'h00);
    checkOutput("reset.dbOe", dbOe, 0);
    checkOutput("reset.pwait", pwait, 0);
    checkOutput("reset.regAddr", regAddr, 8'h00);
    checkOutput("reset.dataOut", dataOut, 8'h00);
    checkOutput("reset.dataStb", dataStb, 1);
    checkOutput("reset.rdStb", rdStb, 0);
    checkOutput("reset.timeoutErr", timeoutErr, 0);
    astb = 1'b1;
    dstb = 1'b1;
    pwr = 1'b0;
    errClr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    applyStimulus("addrWr05",  1, 0, 0, 8'h05, 8'h00, REL_NORMAL);
    applyStimulus("dataWr01",  0, 1, 0, 8'h01, 8'h00, REL_NORMAL);
    applyStimulus("dataWr02a", 0, 1, 0, 8'h02, 8'h00, REL_NORMAL);
    applyStimulus("dataWr02b", 0, 1, 0, 8'h02, 8'h00, REL_NORMAL);
    applyStimulus("dataRdA5",  0, 1, 1, 8'h00, 8'hA5, REL_NORMAL);
    applyStimulus("addrRd",    1, 0, 1, 8'h00, 8'h00, REL_NORMAL);
    applyStimulus("bothStb",   1, 1, 0, 8'h77, 8'h00, REL_NORMAL);

    applyStimulus("timeout",   0, 1, 0, 8'h9E, 8'h00, REL_TIMEOUT);
    checkOutput("timeout.noExtraDataStb", dataPulses, expDataPulses);
    @(posedge clk); #1;
    dstb = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("timeout.errSticky", timeoutErr, modelErr);
    errClr = 1'b1;
    @(posedge clk); #1;
    errClr = 1'b0;
    modelErr = 1'b0;
    checkOutput("errClr.timeoutErr", timeoutErr, modelErr);

    applyStimulus("resetHold", 0, 1, 0, 8'h3C, 8'h00, REL_RESET);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    modelAddr = 8'h00;
    modelData = 8'h00;
    checkOutput("resetHold.pwait", pwait, 0);
    checkOutput("resetHold.dbOe", dbOe, 0);
    checkOutput("resetHold.dataStb", dataStb, 1);
    checkOutput("resetHold.regAddr", regAddr, modelAddr);
    checkOutput("resetHold.dataOut", dataOut, modelData);
    repeat (2) @(posedge clk);
    expectCycle("afterReset", 0, 1, 0, 8'h3C, 8'h00, REL_NORMAL);
    #1;
    rst = 1'b0;
    hostFinish("afterReset", REL_NORMAL);

    applyStimulus("finalWr", 0, 1, 0, 8'hC3, 8'h00, REL_NORMAL);
    repeat (5) @(posedge clk);
    checkOutput("end.queueEmpty", expQ.size(), 0);
    checkOutput("end.dataStbPulses", dataPulses, expDataPulses);
    checkOutput("end.rdStbPulses", rdPulses, expRdPulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
